// File: rtl/delay_scheduler_if.sv
// Request/grant/completion bundle between delay clients and the shared delay scheduler.
// The master side is the client group; the slave side is the scheduler itself.
interface delay_scheduler_if #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned CNT_W   = 13
);
   localparam int unsigned IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_i;
   logic [NUM_REQ*CNT_W-1:0] ticks_i;
   logic                     abort_i;
   logic [NUM_REQ-1:0]       gnt_o;
   logic [NUM_REQ-1:0]       done_o;
   logic                     busy_o;
   logic [IW-1:0]            owner_o;

   modport master (
      output req_i, ticks_i, abort_i,
      input  gnt_o, done_o, busy_o, owner_o
   );

   modport slave (
      input  req_i, ticks_i, abort_i,
      output gnt_o, done_o, busy_o, owner_o
   );
endinterface

// File: rtl/delay_scheduler.sv
// Round-robin owner of a single prescaled tick timer shared by NUM_REQ delay clients.
// One delay runs at a time; the owner gets a one-cycle done pulse when it expires.
module delay_scheduler #(
   parameter int unsigned NUM_REQ  = 3,
   parameter int unsigned CNT_W    = 13,
   parameter int unsigned TICK_DIV = 5000
) (
   input logic              clk,
   input logic              rst_n,
   delay_scheduler_if.slave bus
);
   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned PW = $clog2(TICK_DIV) + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q;
   logic [PW-1:0]      pre_q;
   logic [CNT_W-1:0]   rem_q;
   logic [IW-1:0]      ptr_q;
   logic [IW-1:0]      owner_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic [NUM_REQ-1:0] done_q;
   logic               busy_q;

   logic               win_found;
   logic [IW-1:0]      win_idx;
   logic [CNT_W-1:0]   win_ticks;

   // Walk from farthest to nearest after the pointer so the nearest set request wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_ticks = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_i[i] && ((32'(ptr_q) + 32'(k)) % NUM_REQ == 32'(i))) begin
               win_found = 1'b1;
               win_idx   = IW'(i);
               win_ticks = bus.ticks_i[i*CNT_W +: CNT_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pre_q   <= '0;
         rem_q   <= '0;
         ptr_q   <= IW'(NUM_REQ - 1);
         owner_q <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         gnt_q  <= '0;
         done_q <= '0;
         case (state_q)
            StIdle: begin
               if (win_found && !bus.abort_i) begin
                  state_q <= StRun;
                  rem_q   <= win_ticks;
                  pre_q   <= '0;
                  owner_q <= win_idx;
                  ptr_q   <= win_idx;
                  gnt_q   <= NUM_REQ'(1) << win_idx;
                  busy_q  <= 1'b1;
               end
            end
            StRun: begin
               // Abort outranks an expiry landing on the same edge.
               if (bus.abort_i) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (rem_q == '0) begin
                  state_q <= StDone;
                  done_q  <= NUM_REQ'(1) << owner_q;
               end else if (pre_q == PW'(TICK_DIV - 1)) begin
                  pre_q <= '0;
                  rem_q <= rem_q - CNT_W'(1);
               end else begin
                  pre_q <= pre_q + PW'(1);
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt_o   = gnt_q;
   assign bus.done_o  = done_q;
   assign bus.busy_o  = busy_q;
   assign bus.owner_o = owner_q;
endmodule
